// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-M demultiplexer: select-width
// helper, per-port state encoding and drop-counter width.
package demux_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        PORT_EMPTY = 1'b0,
        PORT_FULL  = 1'b1
    } port_state_e;

    // Width of a select that can address `ports` destinations (never below 1).
    function automatic int sel_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// One-entry holding register for a single destination port: a load fills it,
// a consume empties it unless a load lands in the same cycle.
module demux_hold_reg
    import demux_pkg::*;
#(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [n-1:0] load_data,
    input  logic         consume,
    output logic [n-1:0] data,
    output logic         valid
);

    port_state_e  state_q, state_d;
    logic [n-1:0] data_q, data_d;

    // Next-state and next-data for the EMPTY/FULL port machine
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            PORT_EMPTY: begin
                if (load) begin
                    state_d = PORT_FULL;
                    data_d  = load_data;
                end else begin
                    state_d = PORT_EMPTY;
                end
            end
            PORT_FULL: begin
                // A load while full only arrives together with a consume.
                if (load) begin
                    state_d = PORT_FULL;
                    data_d  = load_data;
                end else if (consume) begin
                    state_d = PORT_EMPTY;
                end else begin
                    state_d = PORT_FULL;
                end
            end
            default: begin
                state_d = PORT_EMPTY;
            end
        endcase
    end

    // Holding register state and data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PORT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == PORT_FULL);

endmodule

// File: rtl/demux_1xm_nbit_reg.sv
// Registered 1-to-M demultiplexer with valid/ready handshake; each destination
// owns a one-entry holding register so a stalled port only blocks its own traffic.
module demux_1xm_nbit_reg
    import demux_pkg::*;
#(
    parameter int n  = 3,
    parameter int m  = 2,
    parameter int sw = sel_width(m)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [n-1:0]          in_data,
    input  logic [sw-1:0]         in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [m*n-1:0]        out_data,
    output logic [m-1:0]          out_valid,
    input  logic [m-1:0]          out_ready,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [sw:0] M_LIMIT = m[sw:0];
    localparam bit          M_POW2  = ((1 << sw) == m);

    logic                  sel_ok_s;
    logic                  in_ready_s;
    logic                  drop_s;
    logic [m-1:0]          load_s;
    logic                  err_sel_q, err_sel_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Select decode, ready mux and one-hot load generation
    always_comb begin
        sel_ok_s   = M_POW2 ? 1'b1 : ({1'b0, in_sel} < M_LIMIT);
        in_ready_s = 1'b1;
        load_s     = '0;
        for (int k = 0; k < m; k++) begin
            if (in_sel == sw'(k)) begin
                in_ready_s = !out_valid[k] || out_ready[k];
                load_s[k]  = in_valid;
            end else begin
                load_s[k]  = 1'b0;
            end
        end
        // Out-of-range selects never match a port, so ready stays 1 and the word is dropped.
        load_s = load_s & {m{in_ready_s}};
        drop_s = in_valid && !sel_ok_s;
    end

    // Error pulse and saturating drop counter next values
    always_comb begin
        err_sel_d = drop_s;
        if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Error pulse and drop counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < m; k++) begin : g_port
        demux_hold_reg #(.n(n)) u_hold (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[k]),
            .load_data (in_data),
            .consume   (out_ready[k]),
            .data      (out_data[k*n +: n]),
            .valid     (out_valid[k])
        );
    end

    assign in_ready = in_ready_s;
    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1xm_nbit_reg.sv
// Bench for demux_1xm_nbit_reg: directed checks on an n=3/m=2 instance and
// drop/saturation plus a randomised per-port queue scoreboard on an n=8/m=3 instance.
module tb_demux_1xm_nbit_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: n=3, m=2
    logic [2:0] a_in_data;
    logic [0:0] a_in_sel;
    logic       a_in_valid, a_in_ready;
    logic [5:0] a_out_data;
    logic [1:0] a_out_valid, a_out_ready;
    logic       a_err_sel;
    logic [7:0] a_drop_cnt;

    // instance B: n=8, m=3 (sel value 3 is invalid)
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_valid, b_in_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid, b_out_ready;
    logic        b_err_sel;
    logic [7:0]  b_drop_cnt;

    demux_1xm_nbit_reg #(.n(3), .m(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .err_sel(a_err_sel),
        .drop_cnt(a_drop_cnt)
    );

    demux_1xm_nbit_reg #(.n(8), .m(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .err_sel(b_err_sel),
        .drop_cnt(b_drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model state for the randomised phase
    logic [7:0] pq [3][$];
    int  drops_m;
    bit  exp_err, hold, exp_rdy;
    int  accepted, cyc;
    logic [7:0] e;

    initial begin
        rst_n = 1'b0;
        a_in_data = 3'd0; a_in_sel = 1'b0; a_in_valid = 1'b0; a_out_ready = 2'b00;
        b_in_data = 8'd0; b_in_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 3'b000;

        // reset / idle
        #3;
        check_val("rst_ov", a_out_valid, 2'b00);
        check_val("rst_od", a_out_data, 6'd0);
        check_val("rst_dc", a_drop_cnt, 8'd0);
        check_val("rst_rdy", a_in_ready, 1'b1);
        check_val("rst_err", a_err_sel, 1'b0);
        check_val("rst_rdy_b", b_in_ready, 1'b1);
        #4 rst_n = 1'b1;
        tick;

        // basic routing
        a_out_ready = 2'b11;
        a_in_data = 3'b101; a_in_sel = 1'b1; a_in_valid = 1'b1;
        #1 check_val("bas_rdy", a_in_ready, 1'b1);
        tick;
        a_in_valid = 1'b0;
        check_val("bas_ov1", a_out_valid, 2'b10);
        check_val("bas_s1", a_out_data[5:3], 3'b101);
        tick;
        check_val("bas_ov1e", a_out_valid, 2'b00);
        a_in_data = 3'b011; a_in_sel = 1'b0; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        check_val("bas_ov0", a_out_valid, 2'b01);
        check_val("bas_s0", a_out_data[2:0], 3'b011);
        tick;
        check_val("bas_ov0e", a_out_valid, 2'b00);

        // backpressure isolation
        a_out_ready = 2'b10;
        a_in_data = 3'b001; a_in_sel = 1'b0; a_in_valid = 1'b1;
        tick;
        a_in_data = 3'b110; a_in_sel = 1'b1;
        #1 check_val("bp_rdy1", a_in_ready, 1'b1);
        tick;
        check_val("bp_ov", a_out_valid, 2'b11);
        check_val("bp_s1", a_out_data[5:3], 3'b110);
        a_in_data = 3'b010; a_in_sel = 1'b0;
        #1 check_val("bp_stall", a_in_ready, 1'b0);
        tick;
        check_val("bp_ov_p1", a_out_valid, 2'b01);
        check_val("bp_s0hold", a_out_data[2:0], 3'b001);
        check_val("bp_stall2", a_in_ready, 1'b0);
        tick;
        check_val("bp_s0hold2", a_out_data[2:0], 3'b001);
        a_out_ready = 2'b11;
        #1 check_val("bp_rel", a_in_ready, 1'b1);
        tick;
        a_in_valid = 1'b0;
        check_val("bp_ov2", a_out_valid, 2'b01);
        check_val("bp_s0w2", a_out_data[2:0], 3'b010);
        tick;
        check_val("bp_empty", a_out_valid, 2'b00);

        // back-to-back same port
        a_out_ready = 2'b01;
        for (int w = 1; w <= 3; w++) begin
            a_in_data = 3'(w); a_in_sel = 1'b0; a_in_valid = 1'b1;
            #1 check_val("b2b_rdy", a_in_ready, 1'b1);
            tick;
            check_val("b2b_ov", a_out_valid[0], 1'b1);
            check_val("b2b_d", a_out_data[2:0], 3'(w));
        end
        a_in_valid = 1'b0;
        tick;
        check_val("b2b_end", a_out_valid, 2'b00);

        // asynchronous reset with a port full
        a_out_ready = 2'b00;
        a_in_data = 3'b111; a_in_sel = 1'b1; a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        check_val("ar_full", a_out_valid, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_ov", a_out_valid, 2'b00);
        check_val("ar_od", a_out_data, 6'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // invalid select on m=3
        b_out_ready = 3'b111;
        b_in_sel = 2'd3; b_in_data = 8'hAA; b_in_valid = 1'b1;
        #1 check_val("drop_rdy", b_in_ready, 1'b1);
        tick;
        b_in_valid = 1'b0;
        check_val("drop_err", b_err_sel, 1'b1);
        check_val("drop_cnt1", b_drop_cnt, 8'd1);
        check_val("drop_ov", b_out_valid, 3'b000);
        tick;
        check_val("drop_err_off", b_err_sel, 1'b0);
        b_in_valid = 1'b1;
        repeat (253) tick;
        check_val("drop_cnt254", b_drop_cnt, 8'd254);
        repeat (46) tick;
        check_val("drop_sat", b_drop_cnt, 8'd255);
        check_val("drop_err_held", b_err_sel, 1'b1);
        b_in_valid = 1'b0;
        tick;
        check_val("drop_err_end", b_err_sel, 1'b0);
        check_val("drop_sat2", b_drop_cnt, 8'd255);

        // randomised scoreboard on instance B
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        drops_m = 0; exp_err = 1'b0; hold = 1'b0; accepted = 0; cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            cyc++;
            b_out_ready = 3'($urandom);
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 9) < 8);
                b_in_sel   = 2'($urandom_range(0, 3));
                b_in_data  = 8'($urandom);
            end
            #1;
            for (int k = 0; k < 3; k++)
                check_val("rnd_ov", b_out_valid[k], pq[k].size() != 0);
            exp_rdy = (b_in_sel == 2'd3) ? 1'b1 :
                      (pq[b_in_sel].size() == 0 || b_out_ready[b_in_sel]);
            check_val("rnd_rdy", b_in_ready, exp_rdy);
            check_val("rnd_err", b_err_sel, exp_err);
            check_val("rnd_dc", b_drop_cnt, drops_m);
            for (int k = 0; k < 3; k++) begin
                if (pq[k].size() != 0 && b_out_ready[k]) begin
                    e = pq[k].pop_front();
                    check_val("rnd_data", b_out_data[k*8 +: 8], e);
                end
            end
            exp_err = b_in_valid && (b_in_sel == 2'd3);
            if (b_in_valid && exp_rdy) begin
                if (b_in_sel != 2'd3) begin
                    pq[b_in_sel].push_back(b_in_data);
                    accepted++;
                end else if (drops_m < 255) begin
                    drops_m++;
                end
            end
            hold = b_in_valid && !exp_rdy;
            tick;
        end
        check_val("rnd_budget", accepted >= 10000, 1'b1);

        // drain whatever is still held
        b_in_valid = 1'b0;
        b_out_ready = 3'b111;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("drn_ov", b_out_valid[k], pq[k].size() != 0);
            if (pq[k].size() != 0) begin
                e = pq[k].pop_front();
                check_val("drn_data", b_out_data[k*8 +: 8], e);
            end
        end
        tick;
        check_val("drn_empty", b_out_valid, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
